// File: rtl/divisible_by_5.sv
// Bit-serial, MSB-first divisibility-by-five detector.
// The state tracks the remainder mod 5; y is registered so it is glitch-free.
module divisible_by_5 (
  input  logic clk,
  input  logic rst,
  input  logic i,
  output logic y
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    R0   = 3'b001,
    R1   = 3'b010,
    R2   = 3'b011,
    R3   = 3'b100,
    R4   = 3'b101
  } state_t;

  state_t state;
  state_t state_next;
  logic   y_next;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      y     <= 1'b0;
    end else begin
      state <= state_next;
      y     <= y_next;
    end
  end

  // Remainder update: r' = (2r + i) mod 5; undefined encodings fall back to IDLE
  always_comb begin
    state_next = IDLE;
    y_next     = 1'b0;
    unique case (state)
      IDLE:    state_next = i ? R1 : R0;
      R0:      state_next = i ? R1 : R0;
      R1:      state_next = i ? R3 : R2;
      R2:      state_next = i ? R0 : R4;
      R3:      state_next = i ? R2 : R1;
      R4:      state_next = i ? R4 : R3;
      default: state_next = IDLE;
    endcase
    y_next = (state_next == R0);
  end

endmodule

// File: tb/tb_divisible_by_5.sv
// Directed bench for divisible_by_5: drives bits on the falling edge and
// checks y 1ns after each rising edge against hand-computed values.
`timescale 1ns/1ps
module tb_divisible_by_5;

  logic clk;
  logic rst;
  logic i;
  logic y;

  int tests;
  int failed;

  divisible_by_5 dut (
    .clk (clk),
    .rst (rst),
    .i   (i),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic exp, input string tag);
    tests++;
    assert (y === exp) else begin
      failed++;
      $error("FAIL %s: y=%b expected %b", tag, y, exp);
    end
  endtask

  // Drive one bit away from the edge, then sample y just after the edge.
  task automatic send(input logic b, input logic exp, input string tag);
    @(negedge clk);
    i = b;
    @(posedge clk);
    #1;
    check(exp, tag);
  endtask

  // Full-cycle reset from the falling edge, released before the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check(1'b0, "reset_hold");
    #2;
    rst = 1'b0;
  endtask

  // Half-cycle pulse between edges; y must drop with no clock edge.
  task automatic pulse_reset(input string tag);
    #1;
    rst = 1'b1;
    #1;
    check(1'b0, tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    i      = 1'b0;

    // Reset dominates: y stays 0 with i toggling
    #1;
    check(1'b0, "reset_async_t0");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i = ~i;
      @(posedge clk);
      #1;
      check(1'b0, "reset_toggle");
    end
    #1;
    rst = 1'b0;
    send(1'b1, 1'b0, "release_first_bit_1");

    // Main stream 1,1,0,0,1,1,1,0,1,0,1: only the 5th bit (value 25) flags
    do_reset();
    send(1'b1, 1'b0, "main_b1_r1");
    send(1'b1, 1'b0, "main_b2_r3");
    send(1'b0, 1'b0, "main_b3_r1");
    send(1'b0, 1'b0, "main_b4_r2");
    send(1'b1, 1'b1, "main_b5_r0");
    send(1'b1, 1'b0, "main_b6_r1");
    send(1'b1, 1'b0, "main_b7_r3");
    send(1'b0, 1'b0, "main_b8_r1");
    send(1'b1, 1'b0, "main_b9_r3");
    send(1'b0, 1'b0, "main_b10_r1");
    send(1'b1, 1'b0, "main_b11_r3");

    // Short multiples: 5 then 10
    do_reset();
    send(1'b1, 1'b0, "five_b1");
    send(1'b0, 1'b0, "five_b2");
    send(1'b1, 1'b1, "five_b3");
    send(1'b0, 1'b1, "ten");

    // Wrap path: 15 = 1111, remainders 1,3,2,0
    do_reset();
    send(1'b1, 1'b0, "fifteen_b1");
    send(1'b1, 1'b0, "fifteen_b2");
    send(1'b1, 1'b0, "fifteen_b3");
    send(1'b1, 1'b1, "fifteen_b4");

    // Zero counts as divisible; then async drop from y=1
    do_reset();
    send(1'b0, 1'b1, "zero");
    pulse_reset("async_drop_from_r0");

    // R4 coverage: 9 = 1001 via R1,R2,R4,R4; then 19 stays in R4
    send(1'b1, 1'b0, "nine_b1_r1");
    send(1'b0, 1'b0, "nine_b2_r2");
    send(1'b0, 1'b0, "nine_b3_r4");
    send(1'b1, 1'b0, "nine_b4_r4");
    send(1'b1, 1'b0, "nineteen_r4");

    // Mid-stream reset discards value 2; stale state would flag after next bit
    do_reset();
    send(1'b1, 1'b0, "mid_pre_b1");
    send(1'b0, 1'b0, "mid_pre_b2");
    pulse_reset("mid_async");
    send(1'b1, 1'b0, "mid_new_b1");
    send(1'b0, 1'b0, "mid_new_b2");
    send(1'b1, 1'b1, "mid_new_b3_five");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
